dmem_ctrl: RTL
==============

Name: dmem_ctrl

Overview:
- Parametrised data-memory controller. Successor to the fixed single-cycle data memory behind the CPU's dmem port.
- Adds a valid/ready request handshake, a configurable number of wait states, a base-address window, and access-fault reporting for misaligned, out-of-range and illegal-op accesses.
- Sits between the CPU load/store unit and the on-chip data RAM.
- Byte/half/word ops use RV32 funct3 encoding.

Parameters:
- ADDR_WIDTH, 32, byte-address width of req_addr.
- DEPTH_WORDS, 1024, number of 32-bit words of storage; power of two, ≥ 4.
- WAIT_STATES, 1, extra cycles between accept and response; 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_addr  in  ADDR_WIDTH  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_op  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result, extended per op; 0 for stores and faults.
- rsp_err  out  1  access fault; qualified by rsp_valid.

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, wait counter 0.
- RAM contents are not reset.
- req_ready = 1 only in IDLE.
- Accept: a request is accepted when req_valid & req_ready at a rising edge. addr, we, op and wdata are registered. Inputs are ignored in all other cycles.
- IDLE → WAIT on accept if WAIT_STATES > 0, with the counter loaded to WAIT_STATES-1.
- IDLE → RESP on accept if WAIT_STATES == 0.
- WAIT: the counter decrements each cycle. At 0, the next edge enters RESP.
- RESP: lasts exactly one cycle. rsp_valid = 1, then → IDLE.
- Latency: rsp_valid is high WAIT_STATES+1 cycles after the accept edge.
- Back-to-back throughput: one request per WAIT_STATES+2 cycles.
- A new request may be presented in the RESP cycle but is not accepted until IDLE.
- Fault checks use the registered request, evaluated before any RAM access:
  - illegal op: 011, 110, 111, or a store with op 100/101;
  - misaligned: H/HU with addr[0] = 1; W with addr[1:0] ≠ 0;
  - out of range: addr < BASE_ADDR or addr ≥ BASE_ADDR + DEPTH_WORDS*4, computed without wrap at ADDR_WIDTH.
- On a fault: no RAM write, rsp_err = 1, rsp_rdata = 0.
- Store: byte-enables come from op and addr[1:0]. Lanes are written with the wdata low byte/half replicated into the selected lane. The write is committed on the edge entering RESP, never earlier.
- Load: the word is read at index (addr-BASE_ADDR)>>2. The lane is selected by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W is passed through. The value is registered into rsp_rdata and held until the next RESP.
- rsp_err is held with rsp_rdata. It is meaningful only with rsp_valid.
- Reset asserted mid-transaction (WAIT or RESP before the edge): return to IDLE. An uncommitted store is discarded. No rsp_valid is emitted.

Optional Feature:
- Macro: DMEM_CTRL_STATS_EN.
- Defined: adds output ports stat_loads, stat_stores, stat_faults, each 32 bits.
  - Each increments on the RESP cycle of a successful load, a successful store, or a fault respectively.
  - All saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- WAIT_STATES=1, BASE 0: SW 0xDEADBEEF @0x10, then LW @0x10 → each rsp_valid exactly 2 cycles after accept; LW rdata 0xDEADBEEF, err 0.
- After the above: LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD; LHU @0x10 → 0x0000BEEF.
- SB 0x55 @0x11, then LW @0x10 → 0xDEAD55EF. SH 0x1234 @0x12, then LW → 0x123455EF.
- Faults: LW @0x2; SH @0x1; LW @DEPTH_WORDS*4; op 011 → all rsp_err=1, rdata 0. Memory at 0x0 is unchanged (verify with a follow-up LW).
- WAIT_STATES=0 with req_valid held high for 4 back-to-back loads → req_ready toggles 1,0 per request; one rsp_valid pulse per request, each 1 cycle after accept.
- Reset asserted in WAIT during SW 0xCAFEBABE @0x20 → no rsp_valid; after release, LW @0x20 returns the old value. With DMEM_CTRL_STATS_EN, the counters read 0 after reset.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request, WAIT_STATES wait cycles, base window and access-fault reporting.
// Define DMEM_CTRL_STATS_EN to add saturating load/store/fault counters (stat_loads, stat_stores, stat_faults).
module dmem_ctrl #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter int                    WAIT_STATES = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_we,
    input  logic [2:0]            req_op,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
`ifdef DMEM_CTRL_STATS_EN
    ,
    output logic [31:0]           stat_loads,
    output logic [31:0]           stat_stores,
    output logic [31:0]           stat_faults
`endif
);

    localparam int IDXW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [ADDR_WIDTH:0] BASE_EXT = {1'b0, BASE_ADDR};

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [2:0]            r_op;
    logic [31:0]           r_wdata;

    logic [31:0]           mem [DEPTH_WORDS];

    logic                  use_in;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cur_we;
    logic [2:0]            cur_op;
    logic [31:0]           cur_wdata;
    logic [ADDR_WIDTH:0]   off;
    logic [IDXW-1:0]       idx;
    logic                  illegal, misaligned, out_of_range, fault;
    logic [31:0]           word, load_val, result_rdata, wlanes;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [3:0]            be;
    logic                  enter_resp;

    // With zero wait states the access happens on the accept edge itself, so the live inputs stand in for the registered request.
    assign use_in    = (state == IDLE);
    assign cur_addr  = use_in ? req_addr  : r_addr;
    assign cur_we    = use_in ? req_we    : r_we;
    assign cur_op    = use_in ? req_op    : r_op;
    assign cur_wdata = use_in ? req_wdata : r_wdata;

    // The offset borrow flags addresses below the window; BASE_ADDR alignment makes the low offset bits the lane/index.
    assign off          = {1'b0, cur_addr} - BASE_EXT;
    assign idx          = off[IDXW+1:2];
    assign out_of_range = off[ADDR_WIDTH] || (off[ADDR_WIDTH-1:IDXW+2] != '0);
    assign misaligned   = ((cur_op[1:0] == 2'b01) && off[0]) ||
                          ((cur_op == 3'b010) && (off[1:0] != 2'b00));
    assign fault        = illegal || misaligned || out_of_range;
    assign enter_resp   = ((state == IDLE) && req_valid && (WAIT_STATES == 0)) ||
                          ((state == WAIT) && (cnt == 4'd0));

    always_comb begin
        illegal  = 1'b0;
        word     = mem[idx];
        byte_v   = word[7:0];
        half_v   = off[1] ? word[31:16] : word[15:0];
        load_val = word;
        be       = 4'b1111;
        wlanes   = cur_wdata;
        case (cur_op)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = cur_we;
            default:                illegal = 1'b1;
        endcase
        case (off[1:0])
            2'b00:   byte_v = word[7:0];
            2'b01:   byte_v = word[15:8];
            2'b10:   byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        case (cur_op)
            3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
            3'b100:  load_val = {24'd0, byte_v};
            3'b001:  load_val = {{16{half_v[15]}}, half_v};
            3'b101:  load_val = {16'd0, half_v};
            default: load_val = word;
        endcase
        case (cur_op[1:0])
            2'b00: begin
                be     = 4'b0001 << off[1:0];
                wlanes = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be     = off[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{cur_wdata[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wlanes = cur_wdata;
            end
        endcase
        result_rdata = (fault || cur_we) ? 32'd0 : load_val;
    end

    // Storage is never reset; a store commits only on the edge that enters RESP, so a reset beforehand drops it.
    always_ff @(posedge clock) begin
        if (enter_resp && cur_we && !fault && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_op      <= 3'd0;
            r_wdata   <= 32'd0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        r_addr    <= req_addr;
                        r_we      <= req_we;
                        r_op      <= req_op;
                        r_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= result_rdata;
                            rsp_err   <= fault;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= result_rdata;
                        rsp_err   <= fault;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef DMEM_CTRL_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_loads  <= 32'd0;
            stat_stores <= 32'd0;
            stat_faults <= 32'd0;
        end else if (state == RESP) begin
            if (rsp_err) begin
                if (stat_faults != 32'hFFFF_FFFF) stat_faults <= stat_faults + 32'd1;
            end else if (r_we) begin
                if (stat_stores != 32'hFFFF_FFFF) stat_stores <= stat_stores + 32'd1;
            end else begin
                if (stat_loads != 32'hFFFF_FFFF) stat_loads <= stat_loads + 32'd1;
            end
        end
    end
`endif

endmodule
